// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: bus widths, operation codes,
// reset constants, FSM states and access-size helpers.
package mem_access_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int ALUOP_BUS    = 8;

  localparam logic [REG_BUS-1:0]      ZERO_WORD    = 32'h0000_0000;
  localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = 5'b00000;

  localparam logic [ALUOP_BUS-1:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [ALUOP_BUS-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALUOP_BUS-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALUOP_BUS-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALUOP_BUS-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALUOP_BUS-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALUOP_BUS-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALUOP_BUS-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALUOP_BUS-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } size_t;

  function automatic size_t op_size(input logic [ALUOP_BUS-1:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SZ_HALF;
      EXE_LW_OP, EXE_SW_OP:             return SZ_WORD;
      default:                          return SZ_NONE;
    endcase
  endfunction

  function automatic logic is_load(input logic [ALUOP_BUS-1:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store(input logic [ALUOP_BUS-1:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_signed_load(input logic [ALUOP_BUS-1:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LH_OP);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus bundle between the MEM stage (master) and the data memory (slave).
interface mem_access_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    input  dbus_rdata, dbus_ack
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    output dbus_rdata, dbus_ack
  );
endinterface

// File: rtl/mem_access_align.sv
// Combinational big-endian lane logic: byte-lane select and store-data
// replication for a new request, and load-data extraction/extension for
// the data returned with the acknowledge.
module mem_access_align
  import mem_access_pkg::*;
(
  input  logic [ALUOP_BUS-1:0] i_req_op,
  input  logic [REG_BUS-1:0]   i_req_addr,
  input  logic [REG_BUS-1:0]   i_req_sdata,
  output logic [REG_BUS-1:0]   o_req_addr,
  output logic [3:0]           o_req_sel,
  output logic [REG_BUS-1:0]   o_req_wdata,
  input  logic [ALUOP_BUS-1:0] i_ld_op,
  input  logic [1:0]           i_ld_lane,
  input  logic [REG_BUS-1:0]   i_rdata,
  output logic [REG_BUS-1:0]   o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  // Request side: size-aligned address, lane enables, replicated store data
  always_comb begin
    o_req_addr  = i_req_addr;
    o_req_sel   = 4'b0000;
    o_req_wdata = ZERO_WORD;
    case (op_size(i_req_op))
      SZ_BYTE: begin
        o_req_sel   = 4'b1000 >> i_req_addr[1:0];
        o_req_wdata = {4{i_req_sdata[7:0]}};
      end
      SZ_HALF: begin
        o_req_addr[0] = 1'b0;
        o_req_sel     = i_req_addr[1] ? 4'b0011 : 4'b1100;
        o_req_wdata   = {2{i_req_sdata[15:0]}};
      end
      SZ_WORD: begin
        o_req_addr[1:0] = 2'b00;
        o_req_sel       = 4'b1111;
        o_req_wdata     = i_req_sdata;
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed lane(s) and sign- or zero-extend
  always_comb begin
    w_sext = is_signed_load(i_ld_op);
    w_byte = i_rdata[31:24];
    case (i_ld_lane)
      2'b00:   w_byte = i_rdata[31:24];
      2'b01:   w_byte = i_rdata[23:16];
      2'b10:   w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_ld_lane[1] ? i_rdata[15:0] : i_rdata[31:16];
    case (op_size(i_ld_op))
      SZ_BYTE: o_ld_data = {{24{w_sext & w_byte[7]}}, w_byte};
      SZ_HALF: o_ld_data = {{16{w_sext & w_half[15]}}, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage of the integer pipeline: issues loads/stores on the data bus
// with a req/ack handshake, stalls upstream while a transfer is open, and
// registers the write-back fields for MEM/WB.
// Optional feature macro: MISALIGN_EXC_EN (misaligned halfword/word
// accesses raise a one-cycle exception instead of being force-aligned).
module mem_access
  import mem_access_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_valid,
  input  logic [REG_ADDR_BUS-1:0] mem_rw,
  input  logic                    mem_wreg,
  input  logic [REG_BUS-1:0]      mem_wdata,
  input  logic [ALUOP_BUS-1:0]    mem_aluop,
  input  logic [REG_BUS-1:0]      mem_addr,
  input  logic [REG_BUS-1:0]      mem_sdata,
  mem_access_if.master            dbus,
  output logic                    stall_req,
  output logic [REG_ADDR_BUS-1:0] wb_rw,
  output logic                    wb_wreg,
  output logic [REG_BUS-1:0]      wb_wdata,
  output logic                    exc_misalign,
  output logic [REG_BUS-1:0]      exc_badaddr
);

  state_t                  r_state, w_state_nxt;
  logic                    r_req, w_req_nxt;
  logic                    r_we, w_we_nxt;
  logic [REG_BUS-1:0]      r_addr, w_addr_nxt;
  logic [3:0]              r_sel, w_sel_nxt;
  logic [REG_BUS-1:0]      r_wdata, w_wdata_nxt;
  logic [ALUOP_BUS-1:0]    r_op, w_op_nxt;
  logic [REG_ADDR_BUS-1:0] r_rw, w_rw_nxt;
  logic [REG_ADDR_BUS-1:0] r_wb_rw, w_wb_rw_nxt;
  logic                    r_wb_wreg, w_wb_wreg_nxt;
  logic [REG_BUS-1:0]      r_wb_wdata, w_wb_wdata_nxt;

  logic                    w_is_mem;
  logic                    w_misalign;
  logic [REG_BUS-1:0]      w_req_addr;
  logic [3:0]              w_req_sel;
  logic [REG_BUS-1:0]      w_req_wdata;
  logic [REG_BUS-1:0]      w_ld_data;

  assign w_is_mem = is_load(mem_aluop) | is_store(mem_aluop);

`ifdef MISALIGN_EXC_EN
  logic               r_exc, w_exc_nxt;
  logic [REG_BUS-1:0] r_badaddr, w_badaddr_nxt;
  size_t              w_size;

  assign w_size       = op_size(mem_aluop);
  assign w_misalign   = ((w_size == SZ_HALF) && mem_addr[0]) ||
                        ((w_size == SZ_WORD) && (mem_addr[1:0] != 2'b00));
  assign exc_misalign = r_exc;
  assign exc_badaddr  = r_badaddr;
`else
  assign w_misalign   = 1'b0;
  assign exc_misalign = 1'b0;
  assign exc_badaddr  = ZERO_WORD;
`endif

  mem_access_align u_align (
    .i_req_op    (mem_aluop),
    .i_req_addr  (mem_addr),
    .i_req_sdata (mem_sdata),
    .o_req_addr  (w_req_addr),
    .o_req_sel   (w_req_sel),
    .o_req_wdata (w_req_wdata),
    .i_ld_op     (r_op),
    .i_ld_lane   (r_addr[1:0]),
    .i_rdata     (dbus.dbus_rdata),
    .o_ld_data   (w_ld_data)
  );

  // Next-state, next bus/write-back values and the stall request
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_sel_nxt      = r_sel;
    w_wdata_nxt    = r_wdata;
    w_op_nxt       = r_op;
    w_rw_nxt       = r_rw;
    w_wb_rw_nxt    = r_wb_rw;
    w_wb_wreg_nxt  = r_wb_wreg;
    w_wb_wdata_nxt = r_wb_wdata;
    stall_req      = 1'b0;
`ifdef MISALIGN_EXC_EN
    w_exc_nxt      = 1'b0;
    w_badaddr_nxt  = r_badaddr;
`endif
    case (r_state)
      ST_IDLE: begin
        if (mem_valid && w_is_mem && !w_misalign) begin
          stall_req     = 1'b1;
          w_req_nxt     = 1'b1;
          w_we_nxt      = is_store(mem_aluop);
          w_addr_nxt    = w_req_addr;
          w_sel_nxt     = w_req_sel;
          w_wdata_nxt   = w_req_wdata;
          w_op_nxt      = mem_aluop;
          w_rw_nxt      = mem_rw;
          w_wb_wreg_nxt = 1'b0;
          w_state_nxt   = ST_BUSY;
        end else if (mem_valid && w_is_mem) begin
          // Misaligned access: no bus cycle, no register write
          w_wb_rw_nxt    = mem_rw;
          w_wb_wreg_nxt  = 1'b0;
          w_wb_wdata_nxt = mem_wdata;
`ifdef MISALIGN_EXC_EN
          w_exc_nxt      = 1'b1;
          w_badaddr_nxt  = mem_addr;
`endif
        end else begin
          w_wb_rw_nxt    = mem_rw;
          w_wb_wreg_nxt  = mem_wreg & mem_valid;
          w_wb_wdata_nxt = mem_wdata;
        end
      end
      ST_BUSY: begin
        stall_req = ~dbus.dbus_ack;
        if (dbus.dbus_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
          if (is_load(r_op)) begin
            w_wb_rw_nxt    = r_rw;
            w_wb_wreg_nxt  = 1'b1;
            w_wb_wdata_nxt = w_ld_data;
          end else begin
            w_wb_wreg_nxt  = 1'b0;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, bus and write-back registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= ZERO_WORD;
      r_sel      <= 4'b0000;
      r_wdata    <= ZERO_WORD;
      r_op       <= '0;
      r_rw       <= NOP_REG_ADDR;
      r_wb_rw    <= NOP_REG_ADDR;
      r_wb_wreg  <= 1'b0;
      r_wb_wdata <= ZERO_WORD;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_sel      <= w_sel_nxt;
      r_wdata    <= w_wdata_nxt;
      r_op       <= w_op_nxt;
      r_rw       <= w_rw_nxt;
      r_wb_rw    <= w_wb_rw_nxt;
      r_wb_wreg  <= w_wb_wreg_nxt;
      r_wb_wdata <= w_wb_wdata_nxt;
    end
  end

`ifdef MISALIGN_EXC_EN
  // Misalignment pulse and faulting-address capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exc     <= 1'b0;
      r_badaddr <= ZERO_WORD;
    end else begin
      r_exc     <= w_exc_nxt;
      r_badaddr <= w_badaddr_nxt;
    end
  end
`endif

  assign dbus.dbus_req   = r_req;
  assign dbus.dbus_we    = r_we;
  assign dbus.dbus_addr  = r_addr;
  assign dbus.dbus_sel   = r_sel;
  assign dbus.dbus_wdata = r_wdata;
  assign wb_rw           = r_wb_rw;
  assign wb_wreg         = r_wb_wreg;
  assign wb_wdata        = r_wb_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: directed instructions, a bench-side model of
// the expected bus and write-back results, and a per-cycle compare process.
module tb_mem_access;
  import mem_access_pkg::*;

`ifdef MISALIGN_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [4:0]  mem_rw;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        stall_req;
  logic [4:0]  wb_rw;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        exc_misalign;
  logic [31:0] exc_badaddr;

  mem_access_if dbus();

  mem_access dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_rw       (mem_rw),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_aluop    (mem_aluop),
    .mem_addr     (mem_addr),
    .mem_sdata    (mem_sdata),
    .dbus         (dbus),
    .stall_req    (stall_req),
    .wb_rw        (wb_rw),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .exc_misalign (exc_misalign),
    .exc_badaddr  (exc_badaddr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // ---- reference model: access size, lanes and data by plain arithmetic ----
  function automatic int op_bytes(input logic [7:0] op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
    return 0;
  endfunction

  function automatic bit op_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic bit op_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  // Byte offset inside the word after rounding down to the access size
  function automatic int model_off(input int n, input logic [31:0] a);
    int o = int'(a[1:0]);
    return o - (o % n);
  endfunction

  function automatic logic [31:0] model_addr(input int n, input logic [31:0] a);
    return a - 32'(int'(a[1:0]) % n);
  endfunction

  function automatic logic [3:0] model_sel(input int n, input logic [31:0] a);
    return 4'(((1 << n) - 1) << (4 - n - model_off(n, a)));
  endfunction

  function automatic logic [31:0] model_wdata(input int n, input logic [31:0] s);
    if (n == 1) return (s & 32'h0000_00FF) * 32'h0101_0101;
    if (n == 2) return (s & 32'h0000_FFFF) * 32'h0001_0001;
    return s;
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] op, input int n,
                                             input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v, mask;
    v    = r >> ((4 - n - model_off(n, a)) * 8);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (n * 8)) - 32'h1);
    v    = v & mask;
    if ((op == EXE_LB_OP || op == EXE_LH_OP) && v[n*8-1]) v = v | ~mask;
    return v;
  endfunction

  // ---- expectations consumed by the compare process ----
  bit          chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_exc;
  logic [31:0] exp_addr, exp_wdata, exp_bad;
  logic [3:0]  exp_sel;
  bit          chk_wb, chk_wreg;
  logic [4:0]  exp_wb_rw;
  logic        exp_wb_wreg;
  logic [31:0] exp_wb_wdata;
  int          stall_cnt;

  always @(negedge clk) begin
    if (chk_en) begin
      if (stall_req) stall_cnt++;
      chk("stall_req", stall_req, exp_stall);
      chk("dbus_req", dbus.dbus_req, exp_req);
      if (exp_req) begin
        chk("dbus_addr", dbus.dbus_addr, exp_addr);
        chk("dbus_sel", dbus.dbus_sel, exp_sel);
        chk("dbus_we", dbus.dbus_we, exp_we);
        if (exp_we) chk("dbus_wdata", dbus.dbus_wdata, exp_wdata);
      end
      if (chk_wb) begin
        chk("wb_rw", wb_rw, exp_wb_rw);
        chk("wb_wreg", wb_wreg, exp_wb_wreg);
        chk("wb_wdata", wb_wdata, exp_wb_wdata);
      end else if (chk_wreg) begin
        chk("wb_wreg", wb_wreg, exp_wb_wreg);
      end
      chk("exc_misalign", exc_misalign, exp_exc);
      if (exp_exc) chk("exc_badaddr", exc_badaddr, exp_bad);
    end
  end

  // One instruction through the MEM slot. lit_* are hand-computed values:
  // lit_sel = lanes of the request, lit_wb = written-back data (or the
  // faulting address for a misalignment exception), lit_stall = stall cycles.
  task automatic run_op(input string name, input logic [7:0] op, input logic valid,
                        input logic [4:0] rw, input logic wreg, input logic [31:0] wdata,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rd, input int waits,
                        input logic [3:0] lit_sel, input logic [31:0] lit_wb,
                        input int lit_stall);
    int   n = op_bytes(op);
    bit   is_mem = valid && (op_load(op) || op_store(op));
    bit   exc = EXC_EN && is_mem && ((int'(addr[1:0]) % n) != 0);
    logic [3:0] seen_sel = 4'b0000;
    mem_valid = valid; mem_aluop = op; mem_rw = rw; mem_wreg = wreg;
    mem_wdata = wdata; mem_addr = addr; mem_sdata = sdata;
    dbus.dbus_ack = 1'b0; dbus.dbus_rdata = 32'h0;
    stall_cnt = 0; exp_exc = 1'b0; chk_wb = 1'b0; chk_wreg = 1'b0;
    exp_req = 1'b0; exp_stall = is_mem && !exc;
    @(posedge clk); #1;
    if (is_mem && !exc) begin
      exp_addr = model_addr(n, addr); exp_sel = model_sel(n, addr);
      exp_we = op_store(op); exp_wdata = model_wdata(n, sdata);
      exp_req = 1'b1; chk_wreg = 1'b1; exp_wb_wreg = 1'b0;
      for (int k = 0; k <= waits; k++) begin
        dbus.dbus_ack   = (k == waits);
        dbus.dbus_rdata = (k == waits) ? rd : 32'h0;
        exp_stall = (k != waits);
        if (k == 0) seen_sel = dbus.dbus_sel;
        @(posedge clk); #1;
      end
      dbus.dbus_ack = 1'b0; dbus.dbus_rdata = 32'h0; mem_valid = 1'b0;
      exp_req = 1'b0; exp_stall = 1'b0;
      if (op_load(op)) begin
        chk_wb = 1'b1; exp_wb_rw = rw; exp_wb_wreg = 1'b1;
        exp_wb_wdata = model_load(op, n, addr, rd);
        chk({name, " lit wb_wdata"}, wb_wdata, lit_wb);
      end else begin
        chk_wb = 1'b0; chk_wreg = 1'b1; exp_wb_wreg = 1'b0;
      end
      chk({name, " lit sel"}, seen_sel, lit_sel);
    end else begin
      mem_valid = 1'b0; exp_stall = 1'b0;
      if (exc) begin
        exp_exc = 1'b1; exp_bad = addr; chk_wreg = 1'b1; exp_wb_wreg = 1'b0;
        chk({name, " lit badaddr"}, exc_badaddr, lit_wb);
      end else begin
        chk_wb = 1'b1; exp_wb_rw = rw; exp_wb_wreg = wreg & valid; exp_wb_wdata = wdata;
        chk({name, " lit wb_wdata"}, wb_wdata, lit_wb);
      end
    end
    @(posedge clk); #1;
    chk({name, " lit stall cycles"}, stall_cnt, lit_stall);
    exp_exc = 1'b0; chk_wb = 1'b0; chk_wreg = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_rw = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'h0;
    mem_aluop = 8'h0; mem_addr = 32'h0; mem_sdata = 32'h0;
    dbus.dbus_ack = 1'b0; dbus.dbus_rdata = 32'h0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_exc = 1'b0;
    exp_addr = 32'h0; exp_wdata = 32'h0; exp_bad = 32'h0; exp_sel = 4'h0;
    chk_wb = 1'b0; chk_wreg = 1'b0; exp_wb_rw = 5'd0; exp_wb_wreg = 1'b0;
    exp_wb_wdata = 32'h0; stall_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset dbus_req", dbus.dbus_req, 32'h0);
    chk("reset dbus_we", dbus.dbus_we, 32'h0);
    chk("reset dbus_sel", dbus.dbus_sel, 32'h0);
    chk("reset dbus_addr", dbus.dbus_addr, 32'h0);
    chk("reset dbus_wdata", dbus.dbus_wdata, 32'h0);
    chk("reset wb_rw", wb_rw, 32'h0);
    chk("reset wb_wreg", wb_wreg, 32'h0);
    chk("reset wb_wdata", wb_wdata, 32'h0);
    chk("reset exc_misalign", exc_misalign, 32'h0);
    chk("reset exc_badaddr", exc_badaddr, 32'h0);
    chk("reset stall_req", stall_req, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    //      name     op          vld   rw     wreg  wdata          addr          sdata          rdata          w  sel      wb             st
    run_op("ADD",   EXE_ADD_OP, 1'b1, 5'd3,  1'b1, 32'h0000_0005, 32'h0,        32'h0,         32'h0,         0, 4'b0000, 32'h0000_0005, 0);
    run_op("LB",    EXE_LB_OP,  1'b1, 5'd4,  1'b1, 32'h0,         32'h0000_0100, 32'h0,        32'h80FF_FFFF, 3, 4'b1000, 32'hFFFF_FF80, 4);
    run_op("LHU",   EXE_LHU_OP, 1'b1, 5'd5,  1'b1, 32'h0,         32'h0000_0102, 32'h0,        32'h1234_ABCD, 0, 4'b0011, 32'h0000_ABCD, 1);
    run_op("SB",    EXE_SB_OP,  1'b1, 5'd6,  1'b0, 32'h0,         32'h0000_0201, 32'h0000_00A5, 32'h0,        1, 4'b0100, 32'h0,         2);
    run_op("LH",    EXE_LH_OP,  1'b1, 5'd8,  1'b1, 32'h0,         32'h0000_0106, 32'h0,        32'h0000_8001, 0, 4'b0011, 32'hFFFF_8001, 1);
    run_op("SH",    EXE_SH_OP,  1'b1, 5'd9,  1'b0, 32'h0,         32'h0000_010A, 32'h1234_BEEF, 32'h0,        0, 4'b0011, 32'h0,         1);
    run_op("SW",    EXE_SW_OP,  1'b1, 5'd10, 1'b0, 32'h0,         32'h0000_020C, 32'hCAFE_F00D, 32'h0,        2, 4'b1111, 32'h0,         3);
    run_op("LBU",   EXE_LBU_OP, 1'b1, 5'd11, 1'b1, 32'h0,         32'h0000_0103, 32'h0,        32'h1234_56F0, 1, 4'b0001, 32'h0000_00F0, 2);
    run_op("LWinv", EXE_LW_OP,  1'b0, 5'd7,  1'b1, 32'h0000_0077, 32'h0000_0400, 32'h0,        32'h0,         0, 4'b0000, 32'h0000_0077, 0);
    run_op("ADDnw", EXE_ADD_OP, 1'b1, 5'd12, 1'b0, 32'h0000_1234, 32'h0,        32'h0,         32'h0,         0, 4'b0000, 32'h0000_1234, 0);
`ifdef MISALIGN_EXC_EN
    run_op("LWmis", EXE_LW_OP,  1'b1, 5'd13, 1'b1, 32'h0,         32'h0000_0103, 32'h0,        32'hDEAD_BEEF, 1, 4'b0000, 32'h0000_0103, 0);
`else
    run_op("LWmis", EXE_LW_OP,  1'b1, 5'd13, 1'b1, 32'h0,         32'h0000_0103, 32'h0,        32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF, 2);
    chk("LWmis lit addr", dbus.dbus_addr, 32'h0000_0100);
`endif

    // Reset while a request is outstanding, then a stray acknowledge
    chk_en = 1'b0;
    mem_valid = 1'b1; mem_aluop = EXE_LW_OP; mem_rw = 5'd14; mem_wreg = 1'b1;
    mem_addr = 32'h0000_0300; mem_sdata = 32'h0; mem_wdata = 32'h0;
    @(posedge clk); #1;
    chk("rstbusy req before", dbus.dbus_req, 32'h1);
    mem_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstbusy req dropped", dbus.dbus_req, 32'h0);
    chk("rstbusy stall", stall_req, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dbus.dbus_ack = 1'b1; dbus.dbus_rdata = 32'hFFFF_FFFF;
    #3;
    chk("rstbusy stall on stray ack", stall_req, 32'h0);
    @(posedge clk); #1;
    dbus.dbus_ack = 1'b0; dbus.dbus_rdata = 32'h0;
    chk("rstbusy wb_wreg", wb_wreg, 32'h0);
    chk("rstbusy wb_wdata", wb_wdata, 32'h0);
    chk("rstbusy req after ack", dbus.dbus_req, 32'h0);
    @(posedge clk); #1;
    chk("rstbusy idle req", dbus.dbus_req, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
